// File: rtl/ship_controller.sv
// Player ship: button-driven position, neighbour/asteroid sensing, lives FSM.
// Optional RESPAWN_EN: a non-fatal hit reloads the start position.
`timescale 1ns/1ps
module ship_controller #(
  parameter int HALF_SIZE     = 13,
  parameter int X_START       = 30,
  parameter int Y_START       = 240,
  parameter int STEP          = 2,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 2,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               empty,
  input  logic               asteroid,
  input  logic               move,
  input  logic               mU,
  input  logic               mD,
  input  logic               mL,
  input  logic               mR,
  output logic               draw_ship,
  output logic [9:0]         xloc,
  output logic [9:0]         yloc,
  output logic [LIVES_W-1:0] lives,
  output logic               hit,
  output logic               invuln,
  output logic               game_over
);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam logic signed [11:0] HS  = 12'(HALF_SIZE);
  localparam logic signed [11:0] HS1 = 12'(HALF_SIZE + 1);
  localparam logic [10:0] X_LO = 11'(HALF_SIZE + 1);
  localparam logic [10:0] X_HI = 11'(X_MAX - HALF_SIZE - 1);
  localparam logic [10:0] Y_LO = 11'(HALF_SIZE + 1);
  localparam logic [10:0] Y_HI = 11'(Y_MAX - HALF_SIZE - 1);
  localparam logic [10:0] STP  = 11'(STEP);
  localparam logic [7:0]  INV_LOAD = 8'(INVULN_FRAMES - 1);

  state_t state, state_nx;

  logic signed [11:0] dx, dy, adx, ady;
  logic in_box, near_x, near_y;
  logic sense, mcyc;
  logic blk_r, blk_l, blk_u, blk_d, coll;
  logic [9:0] x_nx, y_nx, x_mv, y_mv;
  logic [LIVES_W-1:0] lives_nx;
  logic [7:0] inv_cnt, inv_nx;
  logic [3:0] frame_cnt;
  logic hit_nx;

  // One-axis step with saturation; opposite buttons cancel.
  function automatic logic [9:0] step_axis(
    input logic [9:0]  pos,
    input logic        dec,
    input logic        inc,
    input logic        blk_dec,
    input logic        blk_inc,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    logic [10:0] p;
    logic [10:0] up;
    p = {1'b0, pos};
    up = p + STP;
    step_axis = pos;
    if (inc && !dec && !blk_inc)
      step_axis = (up > hi) ? hi[9:0] : up[9:0];
    else if (dec && !inc && !blk_dec)
      step_axis = (p < lo + STP) ? lo[9:0] : 10'(p - STP);
  endfunction

  always_comb begin
    dx  = $signed({2'b00, hcount}) - $signed({2'b00, xloc});
    dy  = $signed({2'b00, vcount}) - $signed({2'b00, yloc});
    adx = dx[11] ? -dx : dx;
    ady = dy[11] ? -dy : dy;
  end

  assign in_box = (adx <= HS) && (ady <= HS);
  assign near_x = adx <= HS1;
  assign near_y = ady <= HS1;
  assign sense  = pixpulse & ~move;
  assign mcyc   = pixpulse & move;

  assign invuln    = (state == INVULN);
  assign game_over = (state == DEAD);
  assign draw_ship = in_box & ~(invuln & frame_cnt[3]);

  // Sticky sense flags; the move cycle clears and drops its own sample.
  always_ff @(posedge clk) begin
    if (rst || mcyc) begin
      blk_r <= 1'b0;
      blk_l <= 1'b0;
      blk_u <= 1'b0;
      blk_d <= 1'b0;
      coll  <= 1'b0;
    end else if (sense) begin
      if (!empty) begin
        if (dx == HS1 && near_y)  blk_r <= 1'b1;
        if (dx == -HS1 && near_y) blk_l <= 1'b1;
        if (dy == HS1 && near_x)  blk_d <= 1'b1;
        if (dy == -HS1 && near_x) blk_u <= 1'b1;
      end
      if (asteroid && in_box) coll <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    lives_nx = lives;
    inv_nx   = inv_cnt;
    hit_nx   = 1'b0;
    x_nx     = xloc;
    y_nx     = yloc;
    x_mv = step_axis(xloc, mL, mR, blk_l, blk_r, X_LO, X_HI);
    y_mv = step_axis(yloc, mU, mD, blk_u, blk_d, Y_LO, Y_HI);
    if (mcyc) begin
      unique case (state)
        ALIVE: begin
          x_nx = x_mv;
          y_nx = y_mv;
          if (coll && lives != '0) begin
            hit_nx   = 1'b1;
            lives_nx = lives - LIVES_W'(1);
            if (lives == LIVES_W'(1)) begin
              state_nx = DEAD;
            end else begin
              state_nx = INVULN;
              inv_nx   = INV_LOAD;
`ifdef RESPAWN_EN
              x_nx = 10'(X_START);
              y_nx = 10'(Y_START);
`endif
            end
          end
        end
        INVULN: begin
          x_nx = x_mv;
          y_nx = y_mv;
          if (inv_cnt == 8'd0) state_nx = ALIVE;
          else inv_nx = inv_cnt - 8'd1;
        end
        DEAD: begin
          state_nx = DEAD;
        end
        default: state_nx = ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIVE;
      xloc      <= 10'(X_START);
      yloc      <= 10'(Y_START);
      lives     <= LIVES_W'(LIVES_INIT);
      inv_cnt   <= 8'd0;
      frame_cnt <= 4'd0;
      hit       <= 1'b0;
    end else begin
      state   <= state_nx;
      xloc    <= x_nx;
      yloc    <= y_nx;
      lives   <= lives_nx;
      inv_cnt <= inv_nx;
      hit     <= hit_nx;
      if (mcyc) frame_cnt <= frame_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ship_controller.sv
// Scoreboard bench for ship_controller with a frame-level reference model.
// Expectations are queued at each move; a monitor checks after the edge.
`timescale 1ns/1ps
module tb_ship_controller;

  localparam int XS  = 30;
  localparam int YS  = 240;
  localparam int XLO = 14;
  localparam int XHI = 625;
  localparam int YLO = 14;
  localparam int YHI = 465;
  localparam int INV = 60;

  logic clk = 1'b0;
  logic rst, pixpulse, empty, asteroid, move;
  logic mU, mD, mL, mR;
  logic [9:0] hcount, vcount, xloc, yloc;
  logic [1:0] lives;
  logic draw_ship, hit, invuln, game_over;

  always #5 clk = ~clk;

  ship_controller dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse),
    .hcount(hcount), .vcount(vcount),
    .empty(empty), .asteroid(asteroid), .move(move),
    .mU(mU), .mD(mD), .mL(mL), .mR(mR),
    .draw_ship(draw_ship), .xloc(xloc), .yloc(yloc),
    .lives(lives), .hit(hit), .invuln(invuln),
    .game_over(game_over)
  );

  int errors = 0;
  int checks = 0;

  int mx, my, ml, minv, mfc;
  bit mdead;
  bit fr, fl, fu, fd, fc;

  typedef struct {
    int x; int y; int l; bit inv; bit go; bit hit;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_reset();
    mx = XS; my = YS; ml = 3; minv = 0; mfc = 0; mdead = 0;
    fr = 0; fl = 0; fu = 0; fd = 0; fc = 0;
  endtask

  task automatic model_move();
    exp_t e;
    bit h;
    h = !mdead && minv == 0 && fc;
    if (!mdead) begin
      if (mR && !mL && !fr) mx = (mx + 2 > XHI) ? XHI : mx + 2;
      else if (mL && !mR && !fl) mx = (mx - 2 < XLO) ? XLO : mx - 2;
      if (mD && !mU && !fd) my = (my + 2 > YHI) ? YHI : my + 2;
      else if (mU && !mD && !fu) my = (my - 2 < YLO) ? YLO : my - 2;
    end
    if (h) begin
      ml--;
      if (ml == 0) mdead = 1;
      else begin
        minv = INV;
`ifdef RESPAWN_EN
        mx = XS;
        my = YS;
`endif
      end
    end else if (minv > 0) begin
      minv--;
    end
    mfc = (mfc + 1) % 16;
    fr = 0; fl = 0; fu = 0; fd = 0; fc = 0;
    e = '{mx, my, ml, minv > 0, mdead, h};
    q.push_back(e);
  endtask

  task automatic pix(input int h, input int v, input bit e,
                     input bit a, input bit m);
    logic [9:0] hh, vv;
    int hi, vi;
    bit inb, blink;
    hh = 10'(h);
    vv = 10'(v);
    hi = int'(hh);
    vi = int'(vv);
    repeat (3) @(negedge clk);
    hcount = hh; vcount = vv; empty = e; asteroid = a;
    move = m; pixpulse = 1'b1;
    #1;
    inb = iabs(hi - mx) <= 13 && iabs(vi - my) <= 13;
    blink = (minv > 0) && ((mfc & 8) != 0);
    chk("draw_ship", draw_ship, inb && !blink);
    if (m) begin
      model_move();
    end else begin
      if (!e) begin
        if (hi == mx + 14 && iabs(vi - my) <= 14) fr = 1;
        if (hi == mx - 14 && iabs(vi - my) <= 14) fl = 1;
        if (vi == my + 14 && iabs(hi - mx) <= 14) fd = 1;
        if (vi == my - 14 && iabs(hi - mx) <= 14) fu = 1;
      end
      if (a && inb) fc = 1;
    end
    @(negedge clk);
    pixpulse = 1'b0; move = 1'b0; empty = 1'b1; asteroid = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {mU, mD, mL, mR} = b;
  endtask

  task automatic move_only(input logic [3:0] b);
    set_btn(b);
    pix(0, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic hit_frame(input logic [3:0] b);
    set_btn(b);
    pix(mx, my, 1'b1, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_frame();
    int n, h, v;
    bit e, a;
    set_btn(4'($urandom_range(0, 15)));
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        h = mx + int'($urandom_range(0, 34)) - 17;
        v = my + int'($urandom_range(0, 34)) - 17;
      end else begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end
      e = $urandom_range(0, 2) != 0;
      a = $urandom_range(0, 99) < 6;
      pix(h, v, e, a, 1'b0);
    end
    pix(mx + int'($urandom_range(0, 4)) - 2, my, 1'b0,
        1'($urandom_range(0, 1)), 1'b1);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    if (pixpulse && move && !rst) begin
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: move seen with no expectation");
      end else begin
        e = q.pop_front();
        chk("xloc", xloc, e.x);
        chk("yloc", yloc, e.y);
        chk("lives", lives, e.l);
        chk("invuln", invuln, e.inv);
        chk("game_over", game_over, e.go);
        chk("hit", hit, e.hit);
      end
      @(posedge clk);
      #1;
      chk("hit_width", hit, 1'b0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pixpulse = 1'b0; empty = 1'b1; asteroid = 1'b0;
    move = 1'b0; hcount = '0; vcount = '0;
    mU = 0; mD = 0; mL = 0; mR = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_xloc", xloc, XS);
    chk("rst_yloc", yloc, YS);
    chk("rst_lives", lives, 3);
    chk("rst_invuln", invuln, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    chk("rst_hit", hit, 1'b0);

    repeat (10) move_only(4'b0001);
    chk("tp_right10", xloc, 50);

    repeat (20) move_only(4'b0010);
    chk("tp_left_sat", xloc, XLO);
    repeat (5) move_only(4'b1100);
    chk("tp_ud_cancel", yloc, YS);

    do_reset();
    set_btn(4'b0001);
    pix(mx + 14, my, 1'b0, 1'b0, 1'b0);
    pix(0, 0, 1'b1, 1'b0, 1'b1);
    chk("tp_blocked", xloc, XS);
    move_only(4'b0001);
    chk("tp_unblocked", xloc, XS + 2);

    do_reset();
    hit_frame(4'b0000);
    repeat (59) hit_frame(4'b0000);
    chk("tp_invuln_lives", lives, 2);
    repeat (5) move_only(4'b0000);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      hit_frame(4'b0001);
      repeat (61) move_only(4'b0100);
    end
    chk("tp_dead", game_over, 1'b1);
    repeat (4) move_only(4'b0101);
    do_reset();
    #1;
    chk("tp_rst_lives", lives, 3);
    chk("tp_rst_go", game_over, 1'b0);

    repeat (35) move_only(4'b0001);
    hit_frame(4'b0001);
`ifdef RESPAWN_EN
    chk("tp_respawn_x", xloc, XS);
`else
    chk("tp_respawn_x", xloc, 102);
`endif

    do_reset();
    for (int f = 0; f < 400; f++) begin
      rand_frame();
      if (mdead && $urandom_range(0, 9) == 0) do_reset();
    end

    repeat (8) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
